key_repeat: RTL and testbench

Multi-channel auto-repeat ("fast advance") generator for push-button and key inputs. Each channel emits one pulse on press, waits an initial delay, repeats at a slow rate, then accelerates to a fast rate while the input stays held. It sits between the input synchronisers/debouncers and the counter or menu logic that consumes single-cycle step pulses.

---
 rtl/key_repeat_if.sv | 18 +
 rtl/key_repeat.sv | 92 +++++++++
 tb/tb_key_repeat.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/key_repeat_if.sv
// key_repeat_if: key inputs and step-pulse outputs of the key_repeat block.
// Ports (via modports):
//   en      global enable, 0 forces every channel idle
//   in      held-key level per channel (synchronous, debounced)
//   rpt_en  per-channel repeat enable, 0 gives press pulse only
//   pulse   single-cycle step pulse per channel
//   held    channel is active (not idle)
//   fast    channel is repeating at the fast rate
interface key_repeat_if #(parameter int CH = 4);
  logic          en;
  logic [CH-1:0] in;
  logic [CH-1:0] rpt_en;
  logic [CH-1:0] pulse;
  logic [CH-1:0] held;
  logic [CH-1:0] fast;
  modport master (output en, in, rpt_en, input pulse, held, fast);
  modport slave (input en, in, rpt_en, output pulse, held, fast);
endinterface

// File: rtl/key_repeat.sv
// key_repeat: per-channel auto-repeat pulse generator (press, delay, slow, fast).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    key_repeat_if slave: en/in/rpt_en in, pulse/held/fast out (registered)
module key_repeat #(
  parameter int CH          = 4,
  parameter int INIT_DELAY  = 20,
  parameter int SLOW_PERIOD = 8,
  parameter int FAST_PERIOD = 2,
  parameter int ACCEL_AFTER = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  key_repeat_if.slave  bus
);
  localparam int PMAX = (INIT_DELAY > SLOW_PERIOD)
                        ? ((INIT_DELAY > FAST_PERIOD) ? INIT_DELAY : FAST_PERIOD)
                        : ((SLOW_PERIOD > FAST_PERIOD) ? SLOW_PERIOD : FAST_PERIOD);
  localparam int PW = $clog2(PMAX + 1);
  localparam int RW = $clog2(ACCEL_AFTER + 1);
  localparam logic [PW-1:0] D1 = PW'(INIT_DELAY - 1);
  localparam logic [PW-1:0] S1 = PW'(SLOW_PERIOD - 1);
  localparam logic [PW-1:0] F1 = PW'(FAST_PERIOD - 1);
  localparam logic [RW-1:0] A1 = RW'(ACCEL_AFTER - 1);
  localparam logic [RW-1:0] AMAX = RW'(ACCEL_AFTER);
  typedef enum logic [2:0] {IDLE, DELAY, SLOW, FAST, HOLD} state_t;
  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [PW-1:0] cnt_q [CH];
  logic [PW-1:0] cnt_d [CH];
  logic [RW-1:0] rep_q [CH];
  logic [RW-1:0] rep_d [CH];
  logic [CH-1:0] due;
  logic [CH-1:0] pulse_q, pulse_d, held_q, held_d, fast_q, fast_d;
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rep_d[i]   = rep_q[i];
      pulse_d[i] = 1'b0;
      // cnt counts cycles already spent in the current period
      due[i] = cnt_q[i] == ((state_q[i] == DELAY) ? D1 : (state_q[i] == SLOW) ? S1 : F1);
      if (!bus.en || !bus.in[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        rep_d[i]   = '0;
      end else if (state_q[i] == IDLE) begin
        state_d[i] = DELAY;
        pulse_d[i] = 1'b1;
      end else if (!bus.rpt_en[i] || state_q[i] == HOLD) begin
        state_d[i] = HOLD;
        cnt_d[i]   = '0;
        rep_d[i]   = '0;
      end else begin
        pulse_d[i] = due[i];
        cnt_d[i]   = due[i] ? '0 : cnt_q[i] + 1'b1;
        if (due[i] && state_q[i] != FAST) begin
          rep_d[i]   = (rep_q[i] < AMAX) ? rep_q[i] + 1'b1 : rep_q[i];
          state_d[i] = (rep_q[i] >= A1) ? FAST : SLOW;
        end
      end
      held_d[i] = state_d[i] != IDLE;
      // fast lags entry to FAST by one cycle so it rises after the last slow pulse
      fast_d[i] = state_d[i] == FAST && state_q[i] == FAST;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        rep_q[i]   <= '0;
      end
      pulse_q <= '0;
      held_q  <= '0;
      fast_q  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rep_q[i]   <= rep_d[i];
      end
      pulse_q <= pulse_d;
      held_q  <= held_d;
      fast_q  <= fast_d;
    end
  end
  assign bus.pulse = pulse_q;
  assign bus.held  = held_q;
  assign bus.fast  = fast_q;
endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat: directed and random checks of key_repeat against a cycle-count model.
module tb_key_repeat;
  localparam int CH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en;
  logic [CH-1:0] in, rpt_en;
  int checks = 0;
  int errors = 0;
  int pc = 0;
  bit act [2][CH];
  bit hd [2][CH];
  int n [2][CH];
  always #5 clk = ~clk;
  key_repeat_if #(.CH(CH)) ifa ();
  key_repeat_if #(.CH(CH)) ifb ();
  assign ifa.en = en;
  assign ifa.in = in;
  assign ifa.rpt_en = rpt_en;
  assign ifb.en = en;
  assign ifb.in = in;
  assign ifb.rpt_en = rpt_en;
  key_repeat #(.CH(CH)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  key_repeat #(.CH(CH), .INIT_DELAY(1), .SLOW_PERIOD(1), .FAST_PERIOD(1), .ACCEL_AFTER(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  function automatic int pd(int d); return d ? 1 : 20; endfunction
  function automatic int ps(int d); return d ? 1 : 8; endfunction
  function automatic int pf(int d); return d ? 1 : 2; endfunction
  function automatic int pa(int d); return d ? 1 : 4; endfunction
  function automatic int last_slow(int d); return 1 + pd(d) + (pa(d) - 1) * ps(d); endfunction
  function automatic bit pulse_at(int d, int c);
    int na;
    na = last_slow(d);
    return c == 1 || (c >= 1 + pd(d) && c <= na && (c - 1 - pd(d)) % ps(d) == 0)
                  || (c > na && (c - na) % pf(d) == 0);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < CH; i++) act[d][i] = 1'b0;
  endtask
  task automatic tick();
    logic [CH-1:0] ep, eh, ef;
    @(posedge clk);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < CH; i++) begin
        if (!rst_n || !en || !in[i]) act[d][i] = 1'b0;
        else if (!act[d][i]) begin
          act[d][i] = 1'b1;
          n[d][i] = 1;
          hd[d][i] = 1'b0;
        end else begin
          n[d][i]++;
          if (!rpt_en[i]) hd[d][i] = 1'b1;
        end
      end
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < CH; i++) begin
        ep[i] = act[d][i] && !hd[d][i] && pulse_at(d, n[d][i]);
        eh[i] = act[d][i];
        ef[i] = act[d][i] && !hd[d][i] && n[d][i] > last_slow(d);
      end
      chk(d ? "b_pulse" : "a_pulse", d ? ifb.pulse : ifa.pulse, ep);
      chk(d ? "b_held" : "a_held", d ? ifb.held : ifa.held, eh);
      chk(d ? "b_fast" : "a_fast", d ? ifb.fast : ifa.fast, ef);
    end
    pc += int'(ifa.pulse[0]);
  endtask
  initial begin
    en = 1'b1;
    in = '0;
    rpt_en = '1;
    clear_model();
    #2;
    chk("rst_pulse", {ifa.pulse, ifb.pulse}, 0);
    chk("rst_held", {ifa.held, ifb.held}, 0);
    chk("rst_fast", {ifa.fast, ifb.fast}, 0);
    #10 rst_n = 1'b1;
    repeat (2) tick();
    in = 4'b0001;
    pc = 0;
    repeat (60) tick();
    chk("ch0_pulse_count", pc, 12);
    in = '0;
    repeat (3) tick();
    in = 4'b0010;
    repeat (28) tick();
    in = '0;
    repeat (2) tick();
    in = 4'b0010;
    repeat (25) tick();
    in = '0;
    repeat (2) tick();
    rpt_en = 4'b1011;
    in = 4'b0100;
    repeat (20) tick();
    rpt_en = '1;
    repeat (20) tick();
    in = '0;
    tick();
    in = '1;
    repeat (10) tick();
    chk("b_all_pulse", ifb.pulse, 4'hF);
    chk("b_all_fast", ifb.fast, 4'hF);
    in = '0;
    tick();
    in = 4'b0001;
    repeat (25) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    repeat (22) tick();
    in = '0;
    tick();
    in = 4'b0001;
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_pulse", {ifa.pulse, ifb.pulse}, 0);
    chk("async_held", {ifa.held, ifb.held}, 0);
    chk("async_fast", {ifa.fast, ifb.fast}, 0);
    clear_model();
    #3 rst_n = 1'b1;
    repeat (30) tick();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 29) == 0) in[i] = ~in[i];
        if ($urandom_range(0, 49) == 0) rpt_en[i] = ~rpt_en[i];
      end
      en = $urandom_range(0, 99) != 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
